fir_tap_sequencer: RTL
======================

FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 Parameter W, default 8: sample and coefficient width, equal to the downstream multiplier width.
REQ-002 Parameter TAPS, default 8: filter length, a power of two, at least 2.
REQ-003 Parameter AW, default 3: log2(TAPS), the address width.
REQ-004 clk  in  1: single clock; all state changes on its rising edge.
REQ-005 clear_n  in  1: synchronous, active-low reset.
REQ-006 in_valid  in  1: a new sample is offered.
REQ-007 in_sample  in  W: sample data.
REQ-008 in_ready  out  1: the sequencer accepts a sample this cycle.
REQ-009 coef_wr_en  in  1: coefficient write strobe.
REQ-010 coef_wr_addr  in  AW: tap index to write.
REQ-011 coef_wr_data  in  W: coefficient value.
REQ-012 mac_a  out  W: sample operand to the multiplier.
REQ-013 mac_b  out  W: coefficient operand to the multiplier.
REQ-014 mac_load  out  1: restart-accumulation request to the accumulator.
REQ-015 mac_clear  out  1: clear request to the accumulator.
REQ-016 result_valid  out  1: the accumulator output holds a finished dot product this cycle.
REQ-017 busy  out  1: a run is in progress (any state other than IDLE).

Function
REQ-018 The state machine SHALL have four states (IDLE, PRIME, MAC, DONE), with all outputs registered or decoded from state only.
REQ-019 IDLE: in_ready=1; on in_valid, write in_sample to delay line entry wptr and go to PRIME; otherwise stay in IDLE.
REQ-020 PRIME: one cycle; mac_load=1, mac_a=0, mac_b=0; tap index k is set to 0; next state is MAC.
REQ-021 MAC: TAPS cycles; each cycle mac_a=dline[(wptr-k) mod TAPS] and mac_b=coef[k]; k increments; after k=TAPS-1, go to DONE.
REQ-022 DONE: one cycle; result_valid=1; wptr advances (wptr+1 mod TAPS); next state is IDLE.
REQ-023 In every state except MAC, mac_a and mac_b SHALL be 0, so the accumulator holds its value.
REQ-024 mac_load SHALL be 1 only in PRIME; result_valid SHALL be 1 only in DONE; in_ready SHALL be 1 only in IDLE.
REQ-025 Latency SHALL be fixed: with the sample accepted in cycle 0, result_valid is high in cycle TAPS+2 and in_ready returns in cycle TAPS+3.
REQ-026 The delay line SHALL wrap modulo TAPS: after TAPS accepts, the oldest sample is overwritten; index arithmetic wraps without sign issues.
REQ-027 Coefficient writes SHALL take effect only in IDLE and are ignored in PRIME, MAC and DONE.
REQ-028 A coefficient write coinciding with a sample accept in IDLE SHALL update the coefficient in time for that run.
REQ-029 in_valid while in_ready=0 SHALL be ignored; in_sample is not captured, and the source must hold it until accepted.
REQ-030 The block SHALL do no arithmetic; widths pass through unchanged, and the product and sum widths are owned downstream.

Reset
REQ-031 clear_n=0 at a clock edge SHALL force state to IDLE, k=0 and wptr=0, and clear all TAPS delay line entries and all TAPS coefficients to 0.
REQ-032 Output values during and after reset SHALL be: mac_a=0, mac_b=0, mac_load=0, result_valid=0, busy=0, in_ready=1.
REQ-033 mac_clear SHALL be 1 for every cycle in which reset was sampled low, and 0 from the first edge with clear_n=1.
REQ-034 Reset mid-run (PRIME, MAC or DONE) SHALL abort the run with no result_valid pulse, and the next accept starts from the cleared delay line.

Verification
REQ-035 Scenario: TAPS=4, coefs {1,2,3,4}; feed samples 1,0,0,0,0 -> result_valid pulses with accumulated results 1,2,3,4,0.
REQ-036 Scenario: coefs {1,1,1,1}; feed 5,6,7,8,9 -> results 5,11,18,26,30 (wrap-around overwrites the 5).
REQ-037 Scenario: hold in_valid=1 continuously -> exactly one accept per TAPS+3 cycles; mac_load sequence is 1 then TAPS cycles with products, result_valid at the cycle offsets given in REQ-025.
REQ-038 Scenario: write coef[2]=9 during MAC -> ignored; the same write in IDLE together with an accept -> used in that run.
REQ-039 Scenario: assert clear_n=0 at MAC tap 2 -> next cycle all outputs at reset values and mac_clear=1; a following impulse run with zero coefficients -> result 0.
REQ-040 Scenario: W=8, samples and coefficients 255 -> mac_a=mac_b=255 presented unmodified on every MAC cycle.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// Sequences one FIR dot product per accepted sample: a delay line and coefficient bank feed an external MAC.
// Latency: accept in cycle 0, mac_load in cycle 1, TAPS MAC cycles, result_valid in cycle TAPS+2, ready again in TAPS+3.
// Backpressure: in_ready is high only in IDLE; in_valid while busy is ignored and the source must hold its sample.
module fir_tap_sequencer #(
  parameter int W    = 8,
  parameter int TAPS = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          in_valid,
  input  logic [W-1:0]  in_sample,
  output logic          in_ready,
  input  logic          coef_wr_en,
  input  logic [AW-1:0] coef_wr_addr,
  input  logic [W-1:0]  coef_wr_data,
  output logic [W-1:0]  mac_a,
  output logic [W-1:0]  mac_b,
  output logic          mac_load,
  output logic          mac_clear,
  output logic          result_valid,
  output logic          busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [W-1:0]  dline_q [TAPS];
  logic [W-1:0]  dline_d [TAPS];
  logic [W-1:0]  coef_q  [TAPS];
  logic [W-1:0]  coef_d  [TAPS];
  logic          mac_clear_q, mac_clear_d;
  logic [AW-1:0] rd_idx;

  // Newest sample sits at wptr; tap k reads k samples back. TAPS is a power
  // of two, so the AW-bit subtraction wraps modulo TAPS on its own.
  assign rd_idx = wptr_q - k_q;

  // Next-state: FSM sequencing, sample capture and IDLE-only coefficient writes.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wptr_d      = wptr_q;
    dline_d     = dline_q;
    coef_d      = coef_q;
    mac_clear_d = ~clear_n;
    case (state_q)
      S_IDLE: begin
        // A write landing with an accept is visible by the first MAC cycle.
        if (coef_wr_en) coef_d[coef_wr_addr] = coef_wr_data;
        if (in_valid) begin
          dline_d[wptr_q] = in_sample;
          state_d         = S_PRIME;
        end
      end
      S_PRIME: begin
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        k_d = k_q + 1'b1;
        if (k_q == AW'(TAPS - 1)) state_d = S_DONE;
      end
      default: begin
        wptr_d  = wptr_q + 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; clear_n wipes the run, both memories and the pointers.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      wptr_q  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wptr_q  <= wptr_d;
      dline_q <= dline_d;
      coef_q  <= coef_d;
    end
  end

  // Accumulator clear tracks the sampled reset level, one cycle behind it.
  always_ff @(posedge clk) begin
    mac_clear_q <= mac_clear_d;
  end

  // Outputs decode from state only; operands are zero outside MAC so the
  // downstream accumulator holds its value.
  always_comb begin
    in_ready     = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    mac_load     = (state_q == S_PRIME);
    result_valid = (state_q == S_DONE);
    mac_clear    = mac_clear_q;
    mac_a        = '0;
    mac_b        = '0;
    if (state_q == S_MAC) begin
      mac_a = dline_q[rd_idx];
      mac_b = coef_q[k_q];
    end
  end

endmodule
